text_writer: RTL and testbench

- Writes characters into the 40x24 text page at $400-$7FF, using the interleaved row layout that the video scanner reads.
- Consumes a character stream over a valid/ready handshake and tracks a cursor.
- Handles CR, BS and form feed (clear screen), and scrolls up one row when output passes the last row.
- Sits between a CPU/UART character source and the shared video RAM port, as the writer end of that memory.

---
 rtl/text_pkg.sv | 37 +++
 rtl/text_writer_if.sv | 22 ++
 rtl/text_rc_counter.sv | 59 +++++
 rtl/text_writer.sv | 189 ++++++++++++++++++
 tb/tb_text_writer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/text_pkg.sv
// text_pkg: shared constants, character codes, FSM state type and the
// screen address map for the text page writer.
package text_pkg;

    localparam int          COLS  = 40;
    localparam int          ROWS  = 24;
    localparam logic [7:0]  BLANK = 8'hA0;
    localparam logic [15:0] BASE  = 16'h0400;

    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [5:0]  LAST_COL = 6'(COLS - 1);

    localparam logic [7:0]  CH_CR = 8'h0D;
    localparam logic [7:0]  CH_BS = 8'h08;
    localparam logic [7:0]  CH_FF = 8'h0C;

    typedef enum logic [2:0] {
        IDLE,
        PUT,
        CLEAR,
        SC_RD,
        SC_LAT,
        SC_WR,
        SC_BLANK
    } state_t;

    // Rows are interleaved: low three row bits select a 128-byte block,
    // the top two bits select a 40-byte third within that block.
    function automatic logic [15:0] text_addr(input logic [4:0] row,
                                              input logic [5:0] col);
        return BASE
             + {6'd0, row[2:0], 7'd0}
             + 16'(row[4:3]) * 16'h0028
             + {10'd0, col};
    endfunction

endpackage

// File: rtl/text_writer_if.sv
// text_ch_if : character stream, valid/ready handshake.
//   master = character source, slave = text_writer.
// text_mem_if: video RAM write port with one-cycle read latency on dbi.
//   master = text_writer, slave = RAM.
interface text_ch_if;
    logic [7:0] ch;
    logic       ch_valid;
    logic       ch_ready;

    modport master (output ch, output ch_valid, input ch_ready);
    modport slave  (input ch, input ch_valid, output ch_ready);
endinterface

interface text_mem_if;
    logic [15:0] adr;
    logic [7:0]  dbo;
    logic [7:0]  dbi;
    logic        we;

    modport master (output adr, output dbo, output we, input dbi);
    modport slave  (input adr, input dbo, input we, output dbi);
endinterface

// File: rtl/text_rc_counter.sv
// text_rc_counter: row/column scan position used by clear, scroll copy
// and the final blank-row fill.
//   phi, rst          : clock, async active-high reset
//   clr, clr_row      : load position (clr_row, 0); wins over step
//   step              : advance column, wrapping to the next row
//   row, col          : current position
//   nxt_row, nxt_col  : position after this cycle's clr/step
//   last              : current position is the bottom-right cell
module text_rc_counter
    import text_pkg::*;
(
    input  logic       phi,
    input  logic       rst,
    input  logic       clr,
    input  logic [4:0] clr_row,
    input  logic       step,
    output logic [4:0] row,
    output logic [5:0] col,
    output logic [4:0] nxt_row,
    output logic [5:0] nxt_col,
    output logic       last
);

    logic [4:0] row_q, row_d;
    logic [5:0] col_q, col_d;

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (clr) begin
            row_d = clr_row;
            col_d = '0;
        end else if (step) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 5'd1;
            end else begin
                col_d = col_q + 6'd1;
            end
        end
    end

    always_ff @(posedge phi or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign row     = row_q;
    assign col     = col_q;
    assign nxt_row = row_d;
    assign nxt_col = col_d;
    assign last    = (row_q == LAST_ROW) && (col_q == LAST_COL);

endmodule

// File: rtl/text_writer.sv
// text_writer: takes characters from a valid/ready stream and writes them
// into the 40x24 interleaved text page, tracking a cursor. Handles CR, BS,
// form feed (clear screen) and scrolls up one row past the bottom.
//   phi, rst          : clock, async active-high reset
//   chs   (slave)     : ch / ch_valid in, ch_ready out
//   mem   (master)    : adr / dbo / we out, dbi in (valid a cycle after adr)
//   cur_row, cur_col  : cursor position
//   busy              : clear or scroll in progress
module text_writer
    import text_pkg::*;
(
    input  logic        phi,
    input  logic        rst,
    text_ch_if.slave    chs,
    text_mem_if.master  mem,
    output logic [4:0]  cur_row,
    output logic [5:0]  cur_col,
    output logic        busy
);

    state_t      state_q, state_d;
    logic [15:0] adr_q, adr_d;
    logic [7:0]  dbo_q, dbo_d;
    logic        we_q, we_d;
    logic [4:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;

    logic       cnt_clr, cnt_step, cnt_last;
    logic [4:0] cnt_clr_row, cnt_row, cnt_nxt_row;
    logic [5:0] cnt_col, cnt_nxt_col;

    logic ready, accept, go_scroll, printable;

    text_rc_counter u_cnt (
        .phi     (phi),
        .rst     (rst),
        .clr     (cnt_clr),
        .clr_row (cnt_clr_row),
        .step    (cnt_step),
        .row     (cnt_row),
        .col     (cnt_col),
        .nxt_row (cnt_nxt_row),
        .nxt_col (cnt_nxt_col),
        .last    (cnt_last)
    );

    assign ready     = (state_q == IDLE) && !rst;
    assign accept    = ready && chs.ch_valid;
    assign printable = (chs.ch >= 8'h20) && (chs.ch <= 8'h7E);

    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dbo_d       = dbo_q;
        we_d        = we_q;
        row_d       = row_q;
        col_d       = col_q;
        cnt_clr     = 1'b0;
        cnt_clr_row = '0;
        cnt_step    = 1'b0;
        go_scroll   = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (printable) begin
                        state_d = PUT;
                        adr_d   = text_addr(row_q, col_q);
                        dbo_d   = chs.ch | 8'h80;
                        we_d    = 1'b1;
                    end else if (chs.ch == CH_CR) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) go_scroll = 1'b1;
                        else                   row_d = row_q + 5'd1;
                    end else if (chs.ch == CH_BS) begin
                        if (col_q != '0) col_d = col_q - 6'd1;
                    end else if (chs.ch == CH_FF) begin
                        state_d = CLEAR;
                        cnt_clr = 1'b1;
                        adr_d   = text_addr(5'd0, 6'd0);
                        dbo_d   = BLANK;
                        we_d    = 1'b1;
                    end
                end
            end
            PUT: begin
                we_d    = 1'b0;
                state_d = IDLE;
                if (col_q != LAST_COL) begin
                    col_d = col_q + 6'd1;
                end else begin
                    col_d = '0;
                    if (row_q == LAST_ROW) go_scroll = 1'b1;
                    else                   row_d = row_q + 5'd1;
                end
            end
            CLEAR: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_step = 1'b1;
                    adr_d    = text_addr(cnt_nxt_row, cnt_nxt_col);
                end
            end
            SC_RD: begin
                // Source address is on the bus this cycle; data arrives next.
                state_d = SC_LAT;
            end
            SC_LAT: begin
                state_d = SC_WR;
                dbo_d   = mem.dbi;
                adr_d   = text_addr(cnt_row - 5'd1, cnt_col);
                we_d    = 1'b1;
            end
            SC_WR: begin
                if (cnt_last) begin
                    state_d     = SC_BLANK;
                    cnt_clr     = 1'b1;
                    cnt_clr_row = LAST_ROW;
                    adr_d       = text_addr(LAST_ROW, 6'd0);
                    dbo_d       = BLANK;
                    we_d        = 1'b1;
                end else begin
                    state_d  = SC_RD;
                    cnt_step = 1'b1;
                    adr_d    = text_addr(cnt_nxt_row, cnt_nxt_col);
                    we_d     = 1'b0;
                end
            end
            SC_BLANK: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    we_d    = 1'b0;
                    row_d   = LAST_ROW;
                    col_d   = '0;
                end else begin
                    cnt_step = 1'b1;
                    adr_d    = text_addr(cnt_nxt_row, cnt_nxt_col);
                end
            end
            default: begin
                state_d = IDLE;
                we_d    = 1'b0;
            end
        endcase

        // Scroll copy starts reading row 1, column 0; cursor sits at (23,0).
        if (go_scroll) begin
            state_d     = SC_RD;
            cnt_clr     = 1'b1;
            cnt_clr_row = 5'd1;
            adr_d       = text_addr(5'd1, 6'd0);
            we_d        = 1'b0;
            col_d       = '0;
        end
    end

    always_ff @(posedge phi or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            adr_q   <= BASE;
            dbo_q   <= BLANK;
            we_q    <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dbo_q   <= dbo_d;
            we_q    <= we_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    assign chs.ch_ready = ready;
    assign mem.adr      = adr_q;
    assign mem.dbo      = dbo_q;
    assign mem.we       = we_q;
    assign cur_row      = row_q;
    assign cur_col      = col_q;
    assign busy         = (state_q == CLEAR)  || (state_q == SC_RD) ||
                          (state_q == SC_LAT) || (state_q == SC_WR) ||
                          (state_q == SC_BLANK);

endmodule

// File: tb/tb_text_writer.sv
module tb_text_writer;

    logic phi = 1'b0;
    logic rst = 1'b0;
    logic [4:0] cur_row;
    logic [5:0] cur_col;
    logic busy;

    text_ch_if  chi ();
    text_mem_if mi ();

    text_writer dut (
        .phi     (phi),
        .rst     (rst),
        .chs     (chi),
        .mem     (mi),
        .cur_row (cur_row),
        .cur_col (cur_col),
        .busy    (busy)
    );

    always #5 phi = ~phi;

    // ---------------- RAM model: $400-$7FF, registered read ----------------
    logic [7:0] mem [0:1023];
    int bad_wr = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + 3);
    endfunction

    always @(posedge phi) begin
        if (mi.we) begin
            if (mi.adr[15:10] == 6'b000001) mem[mi.adr[9:0]] <= mi.dbo;
            else bad_wr <= bad_wr + 1;
        end
        mi.dbi <= mem[mi.adr[9:0]];
    end

    // ---------------- monitor: monotonic counters + write log --------------
    int nrdy = 0, nbusy = 0, viol = 0;
    logic [15:0] wadr [$];
    logic [7:0]  wdat [$];

    always @(negedge phi) begin
        if (!rst) begin
            if (mi.we) begin
                wadr.push_back(mi.adr);
                wdat.push_back(mi.dbo);
            end
            if (!chi.ch_ready) nrdy++;
            if (busy) nbusy++;
            if (busy && chi.ch_ready) viol++;
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] baddr(input int r, input int c);
        return 16'(16'h0400 + (r % 8) * 128 + (r / 8) * 40 + c);
    endfunction

    task automatic do_reset();
        @(negedge phi);
        rst = 1'b1;
        chi.ch_valid = 1'b0;
        repeat (3) @(negedge phi);
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        n = 0;
        @(negedge phi);
        chi.ch = c;
        chi.ch_valid = 1'b1;
        while (!chi.ch_ready && n < 5000) begin
            @(negedge phi);
            n++;
        end
        if (!chi.ch_ready) begin
            chk("send_ready_timeout", chi.ch_ready, 1);
            chi.ch_valid = 1'b0;
        end else begin
            @(posedge phi);
            #1 chi.ch_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge phi);
        while (!chi.ch_ready && n < 5000) begin
            @(negedge phi);
            n++;
        end
        if (!chi.ch_ready) chk("idle_timeout", chi.ch_ready, 1);
    endtask

    // ---------------- behavioural screen model ----------------
    logic [7:0] scr [24][40];
    int mr, mc;

    task automatic model_scroll();
        for (int r = 0; r < 23; r++)
            for (int c = 0; c < 40; c++) scr[r][c] = scr[r + 1][c];
        for (int c = 0; c < 40; c++) scr[23][c] = 8'hA0;
    endtask

    task automatic model_newline();
        mc = 0;
        if (mr == 23) model_scroll();
        else mr++;
    endtask

    task automatic model_apply(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7E) begin
            scr[mr][mc] = c | 8'h80;
            if (mc == 39) model_newline();
            else mc++;
        end else if (c == 8'h0D) begin
            model_newline();
        end else if (c == 8'h08) begin
            if (mc > 0) mc--;
        end else if (c == 8'h0C) begin
            for (int r = 0; r < 24; r++)
                for (int k = 0; k < 40; k++) scr[r][k] = 8'hA0;
            mr = 0;
            mc = 0;
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  c;
        int          rep;
        int          er;
        int          ec;
        int          nwr;
        logic [15:0] ladr;
        logic [7:0]  ldat;
    } vec_t;

    vec_t tv [12];

    initial begin
        int bw, br, bb, err;
        logic [7:0] c;

        for (int i = 0; i < 1024; i++) mem[i] = pat(i);
        chi.ch = 8'h00;
        chi.ch_valid = 1'b0;

        tv[0]  = '{8'h41, 1,  0, 1, 1, 16'h0400, 8'hC1};
        tv[1]  = '{8'h0D, 9,  9, 0, 0, 16'h0000, 8'h00};
        tv[2]  = '{8'h42, 5,  9, 5, 5, 16'h04AC, 8'hC2};
        tv[3]  = '{8'h08, 6,  9, 0, 0, 16'h0000, 8'h00};
        tv[4]  = '{8'h7F, 1,  9, 0, 0, 16'h0000, 8'h00};
        tv[5]  = '{8'h01, 1,  9, 0, 0, 16'h0000, 8'h00};
        tv[6]  = '{8'h7E, 1,  9, 1, 1, 16'h04A8, 8'hFE};
        tv[7]  = '{8'h20, 1,  9, 2, 1, 16'h04A9, 8'hA0};
        tv[8]  = '{8'h80, 1,  9, 2, 0, 16'h0000, 8'h00};
        tv[9]  = '{8'h1F, 1,  9, 2, 0, 16'h0000, 8'h00};
        tv[10] = '{8'h0D, 14, 23, 0, 0, 16'h0000, 8'h00};
        tv[11] = '{8'h31, 1,  23, 1, 1, 16'h07D0, 8'hB1};

        // ---- reset state ----
        #1 rst = 1'b1;
        repeat (2) @(negedge phi);
        chk("rst_we", mi.we, 0);
        chk("rst_adr", mi.adr, 16'h0400);
        chk("rst_dbo", mi.dbo, 8'hA0);
        chk("rst_row", cur_row, 0);
        chk("rst_col", cur_col, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", chi.ch_ready, 0);
        rst = 1'b0;
        @(negedge phi);
        chk("rel_ready", chi.ch_ready, 1);

        // ---- table-driven single-character effects ----
        foreach (tv[i]) begin
            bw = wadr.size();
            br = nrdy;
            for (int k = 0; k < tv[i].rep; k++) begin
                send(tv[i].c);
                wait_idle();
            end
            chk($sformatf("tv%0d_row", i), cur_row, tv[i].er);
            chk($sformatf("tv%0d_col", i), cur_col, tv[i].ec);
            chk($sformatf("tv%0d_nwr", i), wadr.size() - bw, tv[i].nwr);
            chk($sformatf("tv%0d_nrdy", i), nrdy - br, tv[i].nwr);
            if (tv[i].nwr > 0) begin
                chk($sformatf("tv%0d_adr", i), wadr[wadr.size() - 1], tv[i].ladr);
                chk($sformatf("tv%0d_dat", i), wdat[wdat.size() - 1], tv[i].ldat);
            end
        end

        // ---- 40 chars across a full row ----
        do_reset();
        bw = wadr.size();
        for (int k = 0; k < 40; k++) begin
            send(8'h5A);
            wait_idle();
        end
        chk("row_nwr", wadr.size() - bw, 40);
        err = 0;
        for (int k = 0; k < 40 && bw + k < wadr.size(); k++)
            if (wadr[bw + k] !== 16'(16'h0400 + k) || wdat[bw + k] !== 8'hDA) err++;
        chk("row_order", err, 0);
        chk("row_cur_row", cur_row, 1);
        chk("row_cur_col", cur_col, 0);

        // ---- form feed ----
        bw = wadr.size();
        br = nrdy;
        bb = nbusy;
        send(8'h0C);
        wait_idle();
        chk("ff_nwr", wadr.size() - bw, 960);
        chk("ff_nbusy", nbusy - bb, 960);
        chk("ff_nrdy", nrdy - br, 960);
        if (wadr.size() - bw == 960) begin
            chk("ff_first", wadr[bw], 16'h0400);
            chk("ff_last", wadr[bw + 959], 16'h07F7);
            err = 0;
            for (int k = 0; k < 960; k++)
                if (wadr[bw + k] !== baddr(k / 40, k % 40) || wdat[bw + k] !== 8'hA0) err++;
            chk("ff_order", err, 0);
        end
        chk("ff_row", cur_row, 0);
        chk("ff_col", cur_col, 0);

        // ---- scroll from bottom row ----
        send(8'h0D);
        wait_idle();
        send(8'h58);
        wait_idle();
        for (int k = 0; k < 22; k++) begin
            send(8'h0D);
            wait_idle();
        end
        chk("pre_sc_row", cur_row, 23);
        bw = wadr.size();
        bb = nbusy;
        send(8'h0D);
        wait_idle();
        chk("sc_nbusy", nbusy - bb, 2800);
        chk("sc_nwr", wadr.size() - bw, 960);
        chk("sc_moved", mem[10'h000], 8'hD8);
        chk("sc_row1", mem[10'(baddr(1, 0) - 16'h0400)], 8'hA0);
        err = 0;
        for (int k = 0; k < 40; k++) if (mem[10'h3D0 + 10'(k)] !== 8'hA0) err++;
        chk("sc_blank_row", err, 0);
        err = 0;
        for (int k = 16'h78; k <= 16'h7F; k++) if (mem[k] !== pat(k)) err++;
        chk("sc_holes", err, 0);
        chk("sc_row", cur_row, 23);
        chk("sc_col", cur_col, 0);

        // ---- reset in the middle of a clear ----
        do_reset();
        send(8'h0C);
        repeat (100) @(negedge phi);
        chk("mid_we_before", mi.we, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_we_async", mi.we, 0);
        chk("mid_busy_async", busy, 0);
        chk("mid_ready_async", chi.ch_ready, 0);
        repeat (2) @(negedge phi);
        rst = 1'b0;
        @(negedge phi);
        chk("mid_row", cur_row, 0);
        chk("mid_col", cur_col, 0);
        chk("mid_ready", chi.ch_ready, 1);
        chk("mid_busy", busy, 0);
        bw = wadr.size();
        send(8'h41);
        wait_idle();
        chk("mid_nwr", wadr.size() - bw, 1);
        if (wadr.size() > bw) begin
            chk("mid_adr", wadr[bw], 16'h0400);
            chk("mid_dat", wdat[bw], 8'hC1);
        end

        // ---- randomized stream against the screen model ----
        do_reset();
        send(8'h0C);
        wait_idle();
        for (int r = 0; r < 24; r++)
            for (int k = 0; k < 40; k++) scr[r][k] = 8'hA0;
        mr = 0;
        mc = 0;
        for (int n = 0; n < 200; n++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p < 12)      c = 8'h0D;
            else if (p < 17) c = 8'h08;
            else if (p < 18) c = 8'h0C;
            else if (p < 21) c = 8'($urandom_range(0, 255));
            else             c = 8'($urandom_range(32, 126));
            send(c);
            wait_idle();
            model_apply(c);
            chk($sformatf("rnd%0d_row(ch=%0h)", n, c), cur_row, mr);
            chk($sformatf("rnd%0d_col(ch=%0h)", n, c), cur_col, mc);
        end
        err = 0;
        for (int r = 0; r < 24; r++)
            for (int k = 0; k < 40; k++)
                if (mem[10'(baddr(r, k) - 16'h0400)] !== scr[r][k]) err++;
        chk("rnd_screen", err, 0);
        err = 0;
        for (int b = 0; b < 8; b++)
            for (int k = 120; k < 128; k++)
                if (mem[b * 128 + k] !== pat(b * 128 + k)) err++;
        chk("rnd_holes", err, 0);
        chk("bad_writes", bad_wr, 0);
        chk("busy_and_ready", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
